// File: rtl/waterfall_ctrl_if.sv
// Bundle between the waterfall controller and its surroundings: frame handshake,
// spectrum-buffer read port, waterfall RAM write/read addressing and display timing.
interface waterfall_ctrl_if #(
    parameter int unsigned XW   = 10,
    parameter int unsigned ROWW = 8
);
    logic                 i_frame_rdy;
    logic                 o_frame_ack;
    logic                 o_overrun;
    logic                 i_vblank;
    logic [XW-1:0]        o_spec_addr;
    logic [7:0]           i_spec_data;
    logic                 o_wf_we;
    logic [ROWW+XW-1:0]   o_wf_waddr;
    logic [7:0]           o_wf_wdata;
    logic                 i_wf_sync;
    logic                 i_line;
    logic [XW-1:0]        i_pix_x;
    logic [ROWW+XW-1:0]   o_wf_raddr;
    logic                 o_busy;

    // master: the controller itself
    modport master (
        input  i_frame_rdy, i_vblank, i_spec_data, i_wf_sync, i_line, i_pix_x,
        output o_frame_ack, o_overrun, o_spec_addr, o_wf_we, o_wf_waddr, o_wf_wdata,
               o_wf_raddr, o_busy
    );

    // slave: spectrum buffer, RAM and screen generator around it
    modport slave (
        output i_frame_rdy, i_vblank, i_spec_data, i_wf_sync, i_line, i_pix_x,
        input  o_frame_ack, o_overrun, o_spec_addr, o_wf_we, o_wf_waddr, o_wf_wdata,
               o_wf_raddr, o_busy
    );
endinterface

// File: rtl/waterfall_ctrl.sv
// Copies one spectrum line per frame into a circular waterfall RAM during vblank
// and generates display-side row addresses (newest row first, older rows below).
module waterfall_ctrl #(
    parameter int unsigned LINEWIDTH     = 1024,
    parameter int unsigned XW            = 10,
    parameter int unsigned WATERFALLSIZE = 256,
    parameter int unsigned ROWW          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    waterfall_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StCopy, StDone} state_e;

    localparam logic [XW:0]     LastCnt = (XW+1)'(LINEWIDTH);
    localparam logic [XW:0]     CntOne  = (XW+1)'(1);
    localparam logic [XW-1:0]   LastX   = XW'(LINEWIDTH - 1);
    localparam logic [XW-1:0]   XOne    = XW'(1);
    localparam logic [ROWW-1:0] LastRow = ROWW'(WATERFALLSIZE - 1);
    localparam logic [ROWW-1:0] RowOne  = ROWW'(1);

    state_e             state_q, state_d;
    logic [XW:0]        cnt_q, cnt_d;
    logic [ROWW-1:0]    wr_row_q, wr_row_d;
    logic [ROWW-1:0]    newest_q, newest_d;
    logic [ROWW-1:0]    rd_row_q, rd_row_d;
    logic               pending_q, pending_d;
    logic               sync_q;
    logic [ROWW+XW-1:0] raddr_q;

    logic               frame_ack;
    logic               overrun;
    logic               copy_wr;
    logic [XW-1:0]      x_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_row_q  <= '0;
            newest_q  <= '0;
            rd_row_q  <= '0;
            pending_q <= 1'b0;
            sync_q    <= 1'b0;
            raddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_row_q  <= wr_row_d;
            newest_q  <= newest_d;
            rd_row_q  <= rd_row_d;
            pending_q <= pending_d;
            sync_q    <= bus.i_wf_sync;
            raddr_q   <= {rd_row_q, bus.i_pix_x};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_row_d  = wr_row_q;
        newest_d  = newest_q;
        pending_d = pending_q;
        frame_ack = 1'b0;
        overrun   = 1'b0;

        // Only one request can wait behind the one being served.
        if (bus.i_frame_rdy && state_q != StIdle) begin
            if (pending_q) overrun = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.i_frame_rdy || pending_q) begin
                    state_d   = StArmed;
                    // a fresh request arriving as the queued one is taken stays queued
                    pending_d = pending_q & bus.i_frame_rdy;
                end
            end
            StArmed: begin
                if (bus.i_vblank) begin
                    state_d = StCopy;
                    cnt_d   = '0;
                end
            end
            StCopy: begin
                if (!bus.i_vblank)          state_d = StArmed;
                else if (cnt_q == LastCnt)  state_d = StDone;
                else                        cnt_d   = cnt_q + CntOne;
            end
            StDone: begin
                frame_ack = 1'b1;
                wr_row_d  = (wr_row_q == LastRow) ? '0 : wr_row_q + RowOne;
                newest_d  = wr_row_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Display rows: jump to the newest row at the top, then walk back one row per line.
    always_comb begin
        rd_row_d = rd_row_q;
        if (bus.i_wf_sync && !sync_q) begin
            rd_row_d = (state_q == StDone) ? wr_row_q : newest_q;
        end else if (bus.i_line && !bus.i_wf_sync) begin
            rd_row_d = (rd_row_q == '0) ? LastRow : rd_row_q - RowOne;
        end
    end

    // Write path trails the read address by the buffer's one-cycle latency.
    assign copy_wr = (state_q == StCopy) && (cnt_q != '0) && bus.i_vblank;
    assign x_prev  = cnt_q[XW-1:0] - XOne;

    assign bus.o_spec_addr = (state_q != StCopy) ? '0 :
                             (cnt_q == LastCnt)  ? LastX : cnt_q[XW-1:0];
    assign bus.o_wf_we     = copy_wr;
    assign bus.o_wf_waddr  = copy_wr ? {wr_row_q, x_prev} : '0;
    assign bus.o_wf_wdata  = copy_wr ? bus.i_spec_data : '0;
    assign bus.o_frame_ack = frame_ack;
    assign bus.o_overrun   = overrun;
    assign bus.o_busy      = (state_q == StArmed) || (state_q == StCopy);
    assign bus.o_wf_raddr  = raddr_q;

endmodule
